// File: rtl/rf_write_scheduler.sv
// Single write-port scheduler for the 32x32 register file: merges pipeline writeback with queued
// long-latency results, tracks a busy scoreboard and raises decode stalls. Option: RF_FWD_EN.
module rf_write_scheduler #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        wb_hold,
`ifdef RF_FWD_EN
  output logic        fwd_a_hit,
  output logic        fwd_b_hit,
`endif
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] busy_vec
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          hold_q, hold_d;
  logic [31:0]   busy_q, busy_d;

  logic          empty, push, pop;
  logic [4:0]    head_addr;
  logic [31:0]   head_data;
  logic [31:0]   clr_mask, set_mask, eff_busy;

  always_comb begin
    empty     = (count_q == '0);
    lu_ready  = (count_q != CW'(DEPTH));
    push      = lu_valid & lu_ready;
    head_addr = addr_mem_q[rd_ptr_q];
    head_data = data_mem_q[rd_ptr_q];
    // A held pipeline hands the port to the FIFO head even if wb_valid is (illegally) high.
    pop       = !empty && (hold_q || !wb_valid);

    rf_addr = pop ? head_addr : wb_addr;
    rf_data = pop ? head_data : wb_data;
    rf_we   = rst_n && (pop ? (head_addr != '0) : (wb_valid && (wb_addr != '0)));

    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_LIMIT))
      starve_d = starve_q + SW'(1);
    hold_d = (starve_d == SW'(STARVE_LIMIT));

    clr_mask = pop ? (32'b1 << head_addr) : '0;
    set_mask = (lu_issue && (lu_issue_addr != '0)) ? (32'b1 << lu_issue_addr) : '0;
    busy_d   = ((busy_q & ~clr_mask) | set_mask) & ~32'b1;

`ifdef RF_FWD_EN
    eff_busy  = busy_q & ~(rf_we ? (32'b1 << rf_addr) : 32'b0);
    fwd_a_hit = rf_we && (rf_addr == rs1_addr) && (rs1_addr != '0);
    fwd_b_hit = rf_we && (rf_addr == rs2_addr) && (rs2_addr != '0);
`else
    eff_busy  = busy_q;
`endif
    stall    = rst_n && (eff_busy[rs1_addr] || eff_busy[rs2_addr] || eff_busy[rd_addr]);
    wb_hold  = hold_q;
    busy_vec = busy_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= lu_addr;
      data_mem_q[wr_ptr_q] <= lu_data;
    end
  end

  a_no_wb_during_hold: assert property (@(posedge clk) disable iff (!rst_n) wb_hold |-> !wb_valid);

endmodule
